// File: rtl/shiftleft_seq.sv
// shiftleft_seq: multi-cycle logical left shifter.
// The shift amount is split into power-of-two stages (2**(SHAMT_WIDTH-1) .. 1),
// one stage per clock on a single shared work register, so latency is fixed
// regardless of the amount. Any 1-bit pushed past the MSB sets overflow.
module shiftleft_seq #(
    parameter int SHAMT_WIDTH = 5,
    parameter int WIDTH       = 2 ** SHAMT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ctrl_shift,
    input  logic [WIDTH-1:0]       data_operand,
    input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
    output logic                   ready_in,
    output logic                   busy,
    output logic                   data_resultRDY,
    output logic [WIDTH-1:0]       data_result,
    output logic                   overflow
);

    // Stage index only needs to count SHAMT_WIDTH-1 down to 0.
    localparam int STG_W = (SHAMT_WIDTH > 1) ? $clog2(SHAMT_WIDTH) : 1;
    localparam logic [STG_W-1:0]       STAGE_LAST = STG_W'(SHAMT_WIDTH - 1);
    localparam logic [SHAMT_WIDTH:0]   WIDTH_L    = (SHAMT_WIDTH + 1)'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [STG_W-1:0]       stage_q, stage_d;
    logic [WIDTH-1:0]       work_q, work_d;
    logic [SHAMT_WIDTH-1:0] amt_q, amt_d;
    logic                   ovf_q, ovf_d;

    logic                   accept;
    logic                   stage_en;
    logic [SHAMT_WIDTH:0]   step;
    logic [WIDTH-1:0]       shifted;
    logic                   dropped;

    // A start is taken whenever the block is not mid-shift (IDLE or DONE).
    always_comb begin
        accept = ctrl_shift && (state_q != ST_SHIFT);
    end

    // Stage datapath: shift by 2**stage and detect 1-bits leaving the MSB end.
    always_comb begin
        step     = (SHAMT_WIDTH + 1)'(1) << stage_q;
        shifted  = work_q << step;
        dropped  = |(work_q >> (WIDTH_L - step));
        stage_en = amt_q[stage_q];
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (stage_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = accept ? ST_SHIFT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: load on accept, one stage per SHIFT cycle.
    always_comb begin
        stage_d = stage_q;
        work_d  = work_q;
        amt_d   = amt_q;
        ovf_d   = ovf_q;
        if (accept) begin
            stage_d = STAGE_LAST;
            work_d  = data_operand;
            amt_d   = ctrl_shiftamt;
            ovf_d   = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            if (stage_en) begin
                work_d = shifted;
                ovf_d  = ovf_q | dropped;
            end
            if (stage_q != '0) begin
                stage_d = stage_q - STG_W'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_q <= STAGE_LAST;
            work_q  <= '0;
            amt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs decoded from state and registers only.
    always_comb begin
        ready_in       = (state_q != ST_SHIFT);
        busy           = (state_q == ST_SHIFT);
        data_resultRDY = (state_q == ST_DONE);
        data_result    = work_q;
        overflow       = ovf_q;
    end

endmodule

// File: tb/tb_shiftleft_seq.sv
// Self-checking bench for shiftleft_seq: scoreboard of expected results,
// latency, single-pulse ready, start-ignore, back-to-back and async reset.
module tb_shiftleft_seq;

    logic        clock;
    logic        reset;
    logic        ctrl_shift;
    logic [31:0] data_operand;
    logic [4:0]  ctrl_shiftamt;
    logic        ready_in;
    logic        busy;
    logic        data_resultRDY;
    logic [31:0] data_result;
    logic        overflow;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    shiftleft_seq #(
        .SHAMT_WIDTH(5),
        .WIDTH(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ctrl_shift(ctrl_shift),
        .data_operand(data_operand),
        .ctrl_shiftamt(ctrl_shiftamt),
        .ready_in(ready_in),
        .busy(busy),
        .data_resultRDY(data_resultRDY),
        .data_result(data_result),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t model(input logic [31:0] op, input logic [4:0] amt);
        logic [63:0] wide;
        exp_t e;
        wide  = {32'b0, op} << amt;
        e.res = wide[31:0];
        e.ovf = |wide[63:32];
        return e;
    endfunction

    // Called at a negedge with ready_in=1; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] op, input logic [4:0] amt);
        ctrl_shift    = 1'b1;
        data_operand  = op;
        ctrl_shiftamt = amt;
        sb.push_back(model(op, amt));
        @(posedge clock);
        @(negedge clock);
        ctrl_shift    = 1'b0;
        data_operand  = $urandom;
        ctrl_shiftamt = 5'($urandom_range(0, 31));
    endtask

    // Waits for the RDY pulse; lat counts edges from the accepting edge inclusive.
    task automatic collect(input string name, input int start_lat);
        int   lat;
        exp_t e;
        lat = start_lat;
        while (!data_resultRDY && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL %s latency: got %0d expected 6", name, lat);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty expected entry", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (data_result !== e.res) begin
                errors++;
                $display("FAIL %s result: got %08h expected %08h", name, data_result, e.res);
            end
            checks++;
            if (overflow !== e.ovf) begin
                errors++;
                $display("FAIL %s overflow: got %0b expected %0b", name, overflow, e.ovf);
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({data_result, overflow, data_resultRDY, busy, ready_in} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got res=%08h ovf=%0b rdy=%0b busy=%0b ready=%0b expected 0/0/0/0/1",
                     data_result, overflow, data_resultRDY, busy, ready_in);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_shift_vectors;
        logic [31:0] ops[6]  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_FFFF, 32'h8000_0001};
        logic [4:0]  amts[6] = '{5'd31, 5'd16, 5'd0, 5'd4, 5'd17, 5'd1};
        exp_t        held;
        for (int i = 0; i < 6; i++) begin
            held = model(ops[i], amts[i]);
            issue(ops[i], amts[i]);
            collect("vector", 1);
            @(negedge clock);
            checks++;
            if (data_resultRDY !== 1'b0 || ready_in !== 1'b1 || data_result !== held.res) begin
                errors++;
                $display("FAIL rdy_pulse_hold: got rdy=%0b ready=%0b res=%08h expected 0/1/%08h",
                         data_resultRDY, ready_in, data_result, held.res);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            issue($urandom, 5'($urandom_range(0, 31)));
            collect("random", 1);
            @(negedge clock);
        end
    endtask

    task automatic test_ignore_start;
        int pulses;
        issue(32'h0000_00A5, 5'd3);
        checks++;
        if (busy !== 1'b1 || ready_in !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_shift: got busy=%0b ready=%0b expected 1/0", busy, ready_in);
        end
        ctrl_shift    = 1'b1;
        data_operand  = 32'hFFFF_FFFF;
        ctrl_shiftamt = 5'd7;
        @(negedge clock);
        ctrl_shift    = 1'b0;
        collect("ignore_start", 2);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
        end
        checks++;
        if (pulses !== 0 || data_result !== 32'h0000_0528) begin
            errors++;
            $display("FAIL ignore_extra: got pulses=%0d res=%08h expected 0/00000528", pulses, data_result);
        end
    endtask

    task automatic test_back_to_back;
        issue(32'h0F0F_0F0F, 5'd8);
        collect("b2b_first", 1);
        issue(32'h0000_0001, 5'd1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%0b expected 1", busy);
        end
        collect("b2b_second", 1);
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        int pulses;
        issue(32'hCAFE_F00D, 5'd9);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (data_result !== 32'h0 || busy !== 1'b0 || ready_in !== 1'b1 || data_resultRDY !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got res=%08h busy=%0b ready=%0b rdy=%0b ovf=%0b expected 0/0/1/0/0",
                     data_result, busy, ready_in, data_resultRDY, overflow);
        end
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
        end
        checks++;
        if (pulses !== 0 || busy !== 1'b0 || ready_in !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after: got pulses=%0d busy=%0b ready=%0b expected 0/0/1", pulses, busy, ready_in);
        end
        issue(32'h0000_0003, 5'd2);
        collect("after_reset", 1);
        @(negedge clock);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        ctrl_shift    = 1'b0;
        data_operand  = '0;
        ctrl_shiftamt = '0;
        #12;
        test_reset();
        test_shift_vectors();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
